// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT sweep engine and its signature register.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  localparam int unsigned     SIG_W    = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;

  // One MISR step for x^16+x^12+x^5+1 fed with a single serial bit.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] cur, input logic d);
    logic fb;
    fb = cur[SIG_W-1] ^ d;
    return {cur[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
  endfunction

endpackage

// File: rtl/lut_sig_misr.sv
// Serial-input signature register; seeded at sweep start, stepped once per sampled vector.
module lut_sig_misr
  import lut_sweep_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_i,
  input  logic             en_i,
  input  logic             data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (seed_i) begin
      sig_d = SIG_SEED;
    end else if (en_i) begin
      sig_d = misr_next(sig_q, data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/lut_sweep_engine.sv
// Serially loaded N-input truth table with an exhaustive, dwell-paced input sweep.
// Signature compression is built only when LUT_SWEEP_SIG_EN is defined.
module lut_sweep_engine
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned DWELL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  input  logic             start,
  output logic [N_IN-1:0]  in_vec,
  output logic             f_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    ones_cnt,
  output logic [SIG_W-1:0] sig
);

  localparam int unsigned    Depth   = 2 ** N_IN;
  localparam int unsigned    DwW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwW-1:0] DwLast  = DwW'(DWELL - 1);
  localparam logic [N_IN-1:0] VecLast = '1;

  state_e            state_q;
  logic [Depth-1:0]  table_q;
  logic [N_IN-1:0]   vec_q;
  logic [DwW-1:0]    dwell_q;
  logic [N_IN:0]     ones_q;
  logic              busy_q;
  logic              done_q;
  logic              sample;

  // Sample point is the last dwell cycle of each vector.
  assign sample = (state_q == StSweep) && (dwell_q == DwLast);
  assign f_out  = table_q[vec_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      table_q <= '0;
      vec_q   <= '0;
      dwell_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start takes priority; a coincident cfg bit is dropped
          if (start) begin
            state_q <= StSweep;
            busy_q  <= 1'b1;
            vec_q   <= '0;
            dwell_q <= '0;
            ones_q  <= '0;
          end else if (cfg_valid) begin
            table_q <= {cfg_bit, table_q[Depth-1:1]};
          end
        end
        StSweep: begin
          if (sample) begin
            dwell_q <= '0;
            ones_q  <= ones_q + (N_IN + 1)'(f_out);
            vec_q   <= vec_q + N_IN'(1);
            if (vec_q == VecLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            dwell_q <= dwell_q + DwW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign in_vec    = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ones_cnt  = ones_q;

`ifdef LUT_SWEEP_SIG_EN
  logic start_go;
  assign start_go = (state_q == StIdle) && start;

  lut_sig_misr u_sig_misr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .seed_i (start_go),
    .en_i   (sample),
    .data_i (f_out),
    .sig_o  (sig)
  );
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Self-checking bench for lut_sweep_engine (N_IN=4, DWELL=3) against a queue-based reference.
module tb_lut_sweep_engine;

  localparam int N     = 4;
  localparam int DW    = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          cfg_ready;
  logic          start = 1'b0;
  logic [N-1:0]  in_vec;
  logic          f_out;
  logic          busy;
  logic          done;
  logic [N:0]    ones_cnt;
  logic [15:0]   sig;

  int errors = 0;
  int checks = 0;
  bit tbl_q[$];  // reference table: entry v is tbl_q[v]; new bits enter at the top

  lut_sweep_engine #(
    .N_IN  (N),
    .DWELL (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .start     (start),
    .in_vec    (in_vec),
    .f_out     (f_out),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_ones();
    int n = 0;
    for (int v = 0; v < DEPTH; v++) n += int'(tbl_q[v]);
    return n;
  endfunction

  function automatic logic [15:0] model_sig();
    logic [15:0] s = 16'h0000;
`ifdef LUT_SWEEP_SIG_EN
    s = 16'hFFFF;
    for (int v = 0; v < DEPTH; v++) begin
      s = ((s << 1) & 16'hFFFF) ^ ((s[15] ^ tbl_q[v]) ? 16'h1021 : 16'h0000);
    end
`endif
    return s;
  endfunction

  task automatic model_clear();
    tbl_q.delete();
    for (int i = 0; i < DEPTH; i++) tbl_q.push_back(1'b0);
  endtask

  task automatic load_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = w[i];
      tick();
      tbl_q.push_back(w[i]);
      void'(tbl_q.pop_front());
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".in_vec"}, 32'(in_vec), 32'd0);
    check({name, ".f_out"}, 32'(f_out), 32'd0);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".ones_cnt"}, 32'(ones_cnt), 32'd0);
    check({name, ".sig"}, 32'(sig), 32'd0);
  endtask

  // Full sweep with per-cycle checks. disturb pokes start/cfg mid-sweep;
  // cfg_with_start raises cfg_valid in the same cycle as start.
  task automatic run_sweep(input string name, input bit disturb, input bit cfg_with_start);
    int busy_n = 0;
    int v;
    logic [15:0] exp_sig;
    int exp_ones;
    exp_sig  = model_sig();
    exp_ones = model_ones();
    start = 1'b1;
    if (cfg_with_start) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
    end
    tick();
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    for (int t = 0; t < DEPTH * DW; t++) begin
      v = t / DW;
      if (disturb && t == 21) begin
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
      end
      check($sformatf("%s.in_vec[t=%0d]", name, t), 32'(in_vec), 32'(v));
      check($sformatf("%s.f_out[v=%0d]", name, v), 32'(f_out), 32'(tbl_q[v]));
      check($sformatf("%s.done_low[t=%0d]", name, t), 32'(done), 32'd0);
      check($sformatf("%s.cfg_ready_low[t=%0d]", name, t), 32'(cfg_ready), 32'd0);
      if (busy === 1'b1) busy_n++;
      if (disturb && t == 20) begin
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
      end
      tick();
    end
    check({name, ".busy_cycles"}, 32'(busy_n), 32'(DEPTH * DW));
    check({name, ".done_pulse"}, 32'(done), 32'd1);
    check({name, ".busy_end"}, 32'(busy), 32'd0);
    check({name, ".in_vec_wrap"}, 32'(in_vec), 32'd0);
    check({name, ".cfg_ready_done"}, 32'(cfg_ready), 32'd0);
    check({name, ".ones_cnt"}, 32'(ones_cnt), 32'(exp_ones));
    check({name, ".sig"}, 32'(sig), 32'(exp_sig));
    tick();
    check({name, ".done_clear"}, 32'(done), 32'd0);
    check({name, ".cfg_ready_back"}, 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check({name, ".done_single"}, 32'(done), 32'd0);
    check({name, ".ones_hold"}, 32'(ones_cnt), 32'(exp_ones));
    check({name, ".sig_hold"}, 32'(sig), 32'(exp_sig));
  endtask

  initial begin
    int waited;
    logic [15:0] w;
    model_clear();

    // Reset values while rst_n is held low.
    #3;
    check_reset_outputs("reset");
    #9;
    rst_n = 1'b1;
    #1;
    check("reset.cfg_ready", 32'(cfg_ready), 32'd1);
    tick();

    load_bits(32'h0000, 16);
    run_sweep("zeros", 1'b0, 1'b0);

    load_bits(32'hFFFF, 16);
    run_sweep("ones", 1'b0, 1'b0);

    load_bits(32'h6996, 16);
    run_sweep("xor4", 1'b0, 1'b0);

    // Mid-sweep start/cfg must not disturb the sweep or the table.
    run_sweep("disturb", 1'b1, 1'b0);
    run_sweep("after_disturb", 1'b0, 1'b0);

    // start coincident with cfg_valid: bit dropped, table unchanged.
    run_sweep("start_and_cfg", 1'b0, 1'b1);

    // Extra bits beyond the table depth keep shifting.
    load_bits(32'h6996, 16);
    load_bits(32'h1, 1);
    run_sweep("overshift", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      w = 16'($urandom);
      load_bits(32'(w), 16);
      run_sweep($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    // Asynchronous reset mid-sweep at in_vec=9.
    load_bits(32'hA5C3, 16);
    start = 1'b1;
    tick();
    start  = 1'b0;
    waited = 0;
    while (in_vec !== 4'd9 && waited < 60) begin
      tick();
      waited++;
    end
    check("midreset.reach_vec9", 32'(in_vec), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    tick();
    rst_n = 1'b1;
    #1;
    check("midreset.cfg_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midreset.no_done[%0d]", i), 32'(done), 32'd0);
    end
    run_sweep("post_reset", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
